// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register slice: writeback control
// bit positions, the MEM-stage handshake states and the bubble word.
package pipe_pkg;

    localparam int WB_W     = 4;
    localparam int REGWRITE = 3;
    localparam int MEMTOREG = 2;
    localparam int PCTOREG  = 1;
    localparam int HALT     = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam logic [WB_W-1:0] WB_BUBBLE = '0;

    // An instruction touches data memory if it stores or loads (MemtoReg).
    function automatic logic is_mem_op(input logic mem_write,
                                       input logic [WB_W-1:0] wb_ctrl);
        return mem_write | wb_ctrl[MEMTOREG];
    endfunction

endpackage

// File: rtl/pipeline_exmem_if.sv
// EX/MEM boundary bundle: EX-side inputs, memory acknowledge and the
// registered MEM-stage outputs plus pipeline control.
interface pipeline_exmem_if
    import pipe_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int CNT_W = 16
);
    logic [DW-1:0]    alu_result_in;
    logic [DW-1:0]    store_data_in;
    logic [DW-1:0]    pc_plus2_in;
    logic [RW-1:0]    dst_reg_in;
    logic [WB_W-1:0]  wb_ctrl_in;
    logic             mem_write_in;
    logic             flush;
    logic             mem_ack;

    logic [DW-1:0]    alu_result_out;
    logic [DW-1:0]    store_data_out;
    logic [DW-1:0]    pc_plus2_out;
    logic [RW-1:0]    dst_reg_out;
    logic [WB_W-1:0]  wb_ctrl_out;
    logic             mem_write_out;
    logic             mem_req;
    logic             stall;
    logic             mem_done;
    logic             halt_seen;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output alu_result_in, store_data_in, pc_plus2_in, dst_reg_in,
               wb_ctrl_in, mem_write_in, flush, mem_ack,
        input  alu_result_out, store_data_out, pc_plus2_out, dst_reg_out,
               wb_ctrl_out, mem_write_out, mem_req, stall, mem_done,
               halt_seen, stall_cnt
    );

    modport slave (
        input  alu_result_in, store_data_in, pc_plus2_in, dst_reg_in,
               wb_ctrl_in, mem_write_in, flush, mem_ack,
        output alu_result_out, store_data_out, pc_plus2_out, dst_reg_out,
               wb_ctrl_out, mem_write_out, mem_req, stall, mem_done,
               halt_seen, stall_cnt
    );

endinterface

// File: rtl/mem_handshake_fsm.sv
// Data-memory request/acknowledge tracker for the MEM stage. A request is
// outstanding from the edge that captures a memory op until mem_ack; the
// front of the pipe is stalled only while it waits without an ack.
module mem_handshake_fsm
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic             mop_next,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             stall,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cnt
);
    mem_state_t state;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Outputs depend only on state and the ack, never on the EX inputs.
    assign mem_req  = (state == WAIT);
    assign stall    = (state == WAIT) & ~mem_ack;
    assign mem_done = (state == IDLE) | mem_ack;

    // State advances on every capture edge; back-to-back memory ops stay in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (cap && mop_next) state <= WAIT;
                WAIT: if (cap) state <= mop_next ? WAIT : IDLE;
                default: state <= IDLE;
            endcase
            if (stall) stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: rtl/pipeline_exmem.sv
// EX/MEM pipeline register: latches the EX result, store data, PC+2,
// destination and control, inserts bubbles on flush or after a Halt,
// and holds everything while a memory access is outstanding.
module pipeline_exmem
    import pipe_pkg::*;
#(
    parameter int DW    = 16,
    parameter int RW    = 4,
    parameter int CNT_W = 16
)(
    input  logic            clk,
    input  logic            rst,
    pipeline_exmem_if.slave bus
);
    logic             cap;
    logic             bubble;
    logic             mop_next;
    logic             halt_seen_p1;
    logic             stall_w;
    logic             mem_req_w;
    logic             mem_done_w;
    logic [CNT_W-1:0] stall_cnt_w;

    logic [DW-1:0]    alu_result_p1;
    logic [DW-1:0]    store_data_p1;
    logic [DW-1:0]    pc_plus2_p1;
    logic [RW-1:0]    dst_reg_p1;
    logic [WB_W-1:0]  wb_ctrl_p1;
    logic             mem_write_p1;

    // Flush is only seen on capture edges, so a stalled flush simply waits.
    assign cap      = ~stall_w;
    assign bubble   = bus.flush | halt_seen_p1;
    assign mop_next = ~bubble & is_mem_op(bus.mem_write_in, bus.wb_ctrl_in);

    // EX -> MEM register: load the EX word or a bubble, hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_p1 <= '0;
            store_data_p1 <= '0;
            pc_plus2_p1   <= '0;
            dst_reg_p1    <= '0;
            wb_ctrl_p1    <= WB_BUBBLE;
            mem_write_p1  <= 1'b0;
        end else if (cap) begin
            if (bubble) begin
                alu_result_p1 <= '0;
                store_data_p1 <= '0;
                pc_plus2_p1   <= '0;
                dst_reg_p1    <= '0;
                wb_ctrl_p1    <= WB_BUBBLE;
                mem_write_p1  <= 1'b0;
            end else begin
                alu_result_p1 <= bus.alu_result_in;
                store_data_p1 <= bus.store_data_in;
                pc_plus2_p1   <= bus.pc_plus2_in;
                dst_reg_p1    <= bus.dst_reg_in;
                wb_ctrl_p1    <= bus.wb_ctrl_in;
                mem_write_p1  <= bus.mem_write_in;
            end
        end
    end

    // Sticky halt: the Halt itself passes, everything behind it is bubbled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_seen_p1 <= 1'b0;
        end else if (cap && !bus.flush && bus.wb_ctrl_in[HALT]) begin
            halt_seen_p1 <= 1'b1;
        end
    end

    mem_handshake_fsm #(.CNT_W(CNT_W)) u_handshake (
        .clk       (clk),
        .rst       (rst),
        .cap       (cap),
        .mop_next  (mop_next),
        .mem_ack   (bus.mem_ack),
        .mem_req   (mem_req_w),
        .stall     (stall_w),
        .mem_done  (mem_done_w),
        .stall_cnt (stall_cnt_w)
    );

    assign bus.alu_result_out = alu_result_p1;
    assign bus.store_data_out = store_data_p1;
    assign bus.pc_plus2_out   = pc_plus2_p1;
    assign bus.dst_reg_out    = dst_reg_p1;
    assign bus.wb_ctrl_out    = wb_ctrl_p1;
    assign bus.mem_write_out  = mem_write_p1;
    assign bus.mem_req        = mem_req_w;
    assign bus.stall          = stall_w;
    assign bus.mem_done       = mem_done_w;
    assign bus.halt_seen      = halt_seen_p1;
    assign bus.stall_cnt      = stall_cnt_w;

endmodule

// File: tb/tb_pipeline_exmem.sv
// Bench for the EX/MEM register: directed vector table, saturation and
// mid-access reset sequences, then randomized traffic against a model.
module tb_pipeline_exmem;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [15:0] alu, sd, pc;
        logic [3:0]  dst, wb;
        logic        mw, flush, ack;
    } in_t;

    typedef struct packed {
        logic [15:0]      alu, sd, pc;
        logic [3:0]       dst, wb;
        logic             mw, req, stall, done, halt;
        logic [CNT_W-1:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  vi;
        out_t ve;
    } vec_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    pipeline_exmem_if #(.DW(16), .RW(4), .CNT_W(CNT_W)) bus ();

    pipeline_exmem #(.DW(16), .RW(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the word sitting in MEM, whether its memory
    // access is still outstanding, the halt latch and the stall tally.
    in_t              m_word;
    logic             m_busy;
    logic             m_halted;
    logic [CNT_W-1:0] m_cnt;

    function automatic in_t mk_in(logic [15:0] alu, logic [15:0] sd, logic [15:0] pc,
                                  logic [3:0] dst, logic [3:0] wb, logic mw,
                                  logic flush, logic ack);
        in_t v;
        v.alu = alu; v.sd = sd; v.pc = pc; v.dst = dst; v.wb = wb;
        v.mw = mw; v.flush = flush; v.ack = ack;
        return v;
    endfunction

    function automatic out_t out_of(in_t x, logic req, logic stall, logic done,
                                    logic halt, logic [CNT_W-1:0] cnt);
        out_t o;
        o.alu = x.alu; o.sd = x.sd; o.pc = x.pc; o.dst = x.dst; o.wb = x.wb;
        o.mw = x.mw; o.req = req; o.stall = stall; o.done = done;
        o.halt = halt; o.cnt = cnt;
        return o;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.alu   = bus.alu_result_out;
        s.sd    = bus.store_data_out;
        s.pc    = bus.pc_plus2_out;
        s.dst   = bus.dst_reg_out;
        s.wb    = bus.wb_ctrl_out;
        s.mw    = bus.mem_write_out;
        s.req   = bus.mem_req;
        s.stall = bus.stall;
        s.done  = bus.mem_done;
        s.halt  = bus.halt_seen;
        s.cnt   = bus.stall_cnt;
        return s;
    endfunction

    task automatic drive(in_t v);
        bus.alu_result_in = v.alu;
        bus.store_data_in = v.sd;
        bus.pc_plus2_in   = v.pc;
        bus.dst_reg_in    = v.dst;
        bus.wb_ctrl_in    = v.wb;
        bus.mem_write_in  = v.mw;
        bus.flush         = v.flush;
        bus.mem_ack       = v.ack;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = sample();
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (alu sd pc dst wb mw req stall done halt cnt)",
                      name, act, exp);
    endtask

    function automatic out_t model_expect(logic ack);
        return out_of(m_word, m_busy, m_busy & ~ack, ~m_busy | ack, m_halted, m_cnt);
    endfunction

    task automatic model_reset();
        m_word   = '0;
        m_busy   = 1'b0;
        m_halted = 1'b0;
        m_cnt    = '0;
    endtask

    // One clock edge: a waiting access without ack freezes the stage and
    // counts a stall; otherwise the next instruction (or a bubble) moves in.
    task automatic model_edge(in_t v);
        if (m_busy && !v.ack) begin
            if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else begin
            if (v.flush || m_halted) m_word = '0;
            else m_word = v;
            m_word.flush = 1'b0;
            m_word.ack   = 1'b0;
            if (!v.flush && v.wb[0]) m_halted = 1'b1;
            m_busy = m_word.mw | m_word.wb[2];
        end
    endtask

    task automatic do_reset(string name);
        rst = 1'b0;
        drive('0);
        #1;
        check(name, out_of('0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    vec_t tab[22];

    initial begin
        in_t nop, add1, lw1, add2, add2a, sw1, lw2, nopa, sw2, sw3;
        in_t addf, addfa, hlt, add3, rv;

        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        drive('0);
        model_reset();

        nop   = '0;
        nopa  = mk_in(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
        add1  = mk_in(16'h1234, 16'h0000, 16'h0102, 4'd3, 4'b1000, 1'b0, 1'b0, 1'b0);
        lw1   = mk_in(16'h0040, 16'h0000, 16'h0104, 4'd5, 4'b1100, 1'b0, 1'b0, 1'b0);
        add2  = mk_in(16'h1111, 16'h0000, 16'h0106, 4'd6, 4'b1000, 1'b0, 1'b0, 1'b0);
        add2a = mk_in(16'h1111, 16'h0000, 16'h0106, 4'd6, 4'b1000, 1'b0, 1'b0, 1'b1);
        sw1   = mk_in(16'h0080, 16'hBEEF, 16'h0108, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
        lw2   = mk_in(16'h0082, 16'h0000, 16'h010A, 4'd7, 4'b1100, 1'b0, 1'b0, 1'b1);
        sw2   = mk_in(16'h00A0, 16'h1234, 16'h010C, 4'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
        sw3   = mk_in(16'h00B0, 16'h5555, 16'h010E, 4'd0, 4'b0000, 1'b1, 1'b0, 1'b0);
        addf  = mk_in(16'h2222, 16'h0000, 16'h0110, 4'd2, 4'b1000, 1'b0, 1'b1, 1'b0);
        addfa = mk_in(16'h2222, 16'h0000, 16'h0110, 4'd2, 4'b1000, 1'b0, 1'b1, 1'b1);
        hlt   = mk_in(16'h0000, 16'h0000, 16'h0112, 4'd0, 4'b0001, 1'b0, 1'b0, 1'b0);
        add3  = mk_in(16'h3333, 16'h0000, 16'h0114, 4'd1, 4'b1000, 1'b0, 1'b0, 1'b0);

        // Each row: inputs driven for a cycle, outputs expected in that same
        // cycle (registers from the previous edge, handshake from this ack).
        tab[0]  = '{add1,  out_of(nop,  0, 0, 1, 0, 0)};
        tab[1]  = '{lw1,   out_of(add1, 0, 0, 1, 0, 0)};
        tab[2]  = '{add2,  out_of(lw1,  1, 1, 0, 0, 0)};
        tab[3]  = '{add2,  out_of(lw1,  1, 1, 0, 0, 1)};
        tab[4]  = '{add2,  out_of(lw1,  1, 1, 0, 0, 2)};
        tab[5]  = '{add2a, out_of(lw1,  1, 0, 1, 0, 3)};
        tab[6]  = '{nop,   out_of(add2, 0, 0, 1, 0, 3)};
        tab[7]  = '{sw1,   out_of(nop,  0, 0, 1, 0, 3)};
        tab[8]  = '{lw2,   out_of(sw1,  1, 0, 1, 0, 3)};
        tab[9]  = '{nopa,  out_of(lw2,  1, 0, 1, 0, 3)};
        tab[10] = '{nop,   out_of(nop,  0, 0, 1, 0, 3)};
        tab[11] = '{sw2,   out_of(nop,  0, 0, 1, 0, 3)};
        tab[12] = '{nop,   out_of(nop,  0, 0, 1, 0, 3)};
        tab[13] = '{sw3,   out_of(nop,  0, 0, 1, 0, 3)};
        tab[14] = '{addf,  out_of(sw3,  1, 1, 0, 0, 3)};
        tab[15] = '{addf,  out_of(sw3,  1, 1, 0, 0, 4)};
        tab[16] = '{addfa, out_of(sw3,  1, 0, 1, 0, 5)};
        tab[17] = '{nop,   out_of(nop,  0, 0, 1, 0, 5)};
        tab[18] = '{hlt,   out_of(nop,  0, 0, 1, 0, 5)};
        tab[19] = '{add3,  out_of(hlt,  0, 0, 1, 1, 5)};
        tab[20] = '{add3,  out_of(nop,  0, 0, 1, 1, 5)};
        tab[21] = '{add3,  out_of(nop,  0, 0, 1, 1, 5)};

        do_reset("reset_initial");

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive(tab[i].vi);
            #1;
            check($sformatf("vec%0d", i), tab[i].ve);
        end

        // Halt latch survives until reset.
        do_reset("reset_clears_halt");

        // Long stall saturates the counter, then reset abandons the access.
        @(negedge clk);
        drive(lw1);
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(nop);
        end
        #1;
        check("stall_saturate", out_of(lw1, 1, 1, 0, 0, {CNT_W{1'b1}}));
        #1;
        rst = 1'b0;
        #1;
        check("reset_mid_wait", out_of(nop, 0, 0, 1, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Randomized traffic with periodic resets to re-open halted streams.
        for (int c = 0; c < 900; c++) begin
            if (c % 150 == 149) begin
                @(negedge clk);
                do_reset("reset_random");
            end
            @(negedge clk);
            rv.alu   = 16'($urandom);
            rv.sd    = 16'($urandom);
            rv.pc    = 16'($urandom);
            rv.dst   = 4'($urandom);
            rv.wb    = {3'($urandom), ($urandom_range(0, 199) == 0)};
            rv.mw    = 1'($urandom);
            rv.flush = ($urandom_range(0, 9) == 0);
            rv.ack   = 1'($urandom);
            drive(rv);
            #1;
            check($sformatf("rand%0d", c), model_expect(rv.ack));
            model_edge(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
